// File: rtl/alu_j.sv
// alu_j: 8-bit combinational ALU with carry/borrow/zero flags and a register holding the last non-NOP outcome.
// Optional rotate opcodes (ROL/ROR) are enabled by defining ALU_J_ROTATE_EN.
module alu_j #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_BITS = 5,
  parameter int PARAM_BITS  = 8,
  parameter int STATUS_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OPCODE_BITS-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]  operand1,
  input  logic [DATA_WIDTH-1:0]  operand2,
  input  logic [PARAM_BITS-1:0]  param,
  output logic [DATA_WIDTH-1:0]  result,
  output logic [STATUS_BITS-1:0] status,
  output logic [DATA_WIDTH-1:0]  result_q,
  output logic [STATUS_BITS-1:0] status_q
);

  localparam int SHIFT_BITS = $clog2(DATA_WIDTH);

  localparam logic [OPCODE_BITS-1:0] OP_ADD = OPCODE_BITS'(1);
  localparam logic [OPCODE_BITS-1:0] OP_SUB = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] OP_AND = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_OR  = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] OP_NOT = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] OP_XOR = OPCODE_BITS'(6);
  localparam logic [OPCODE_BITS-1:0] OP_SHL = OPCODE_BITS'(7);
  localparam logic [OPCODE_BITS-1:0] OP_SHR = OPCODE_BITS'(8);
  localparam logic [OPCODE_BITS-1:0] OP_VAL = OPCODE_BITS'(9);
`ifdef ALU_J_ROTATE_EN
  localparam logic [OPCODE_BITS-1:0] OP_ROL = OPCODE_BITS'(10);
  localparam logic [OPCODE_BITS-1:0] OP_ROR = OPCODE_BITS'(11);
`endif

  logic [DATA_WIDTH-1:0]   result_next;
  logic                    carry_next;
  logic                    borrow_next;
  logic                    active_next;
  logic [2*DATA_WIDTH-1:0] wide_next;
  logic [SHIFT_BITS-1:0]   shamt;

  logic [DATA_WIDTH-1:0]   result_reg;
  logic [STATUS_BITS-1:0]  status_reg;

  // Only the low log2(DATA_WIDTH) bits of param steer the shifter.
  assign shamt = param[SHIFT_BITS-1:0];

  always_comb begin
    result_next = '0;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    active_next = 1'b1;
    wide_next   = '0;
    case (opcode)
      OP_ADD: {carry_next, result_next} = {1'b0, operand1} + {1'b0, operand2};
      OP_SUB: begin
        result_next = operand1 - operand2;
        borrow_next = (operand1 < operand2);
      end
      OP_AND: result_next = operand1 & operand2;
      OP_OR:  result_next = operand1 | operand2;
      OP_NOT: result_next = ~operand2;
      OP_XOR: result_next = operand1 ^ operand2;
      // Shifts run in a double-width window so the bits pushed out can be flagged.
      OP_SHL: begin
        wide_next   = {{DATA_WIDTH{1'b0}}, operand1} << shamt;
        result_next = wide_next[DATA_WIDTH-1:0];
        carry_next  = |wide_next[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      OP_SHR: begin
        wide_next   = {operand1, {DATA_WIDTH{1'b0}}} >> shamt;
        result_next = wide_next[2*DATA_WIDTH-1:DATA_WIDTH];
        borrow_next = |wide_next[DATA_WIDTH-1:0];
      end
      OP_VAL: result_next = param[DATA_WIDTH-1:0];
`ifdef ALU_J_ROTATE_EN
      OP_ROL: begin
        wide_next   = {operand1, operand1} << shamt;
        result_next = wide_next[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      OP_ROR: begin
        wide_next   = {operand1, operand1} >> shamt;
        result_next = wide_next[DATA_WIDTH-1:0];
      end
`endif
      default: active_next = 1'b0;
    endcase
  end

  // Zero flag needs a real operation with no carry/borrow, so 255+1 is not "zero".
  assign result = result_next;
  assign status = {active_next && (result_next == '0) && !carry_next && !borrow_next,
                   borrow_next, carry_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      status_reg <= '0;
    end else if (active_next) begin
      result_reg <= result;
      status_reg <= status;
    end
  end

  assign result_q = result_reg;
  assign status_q = status_reg;

endmodule

// File: tb/tb_alu_j.sv
// Bench for alu_j: table-driven vectors through a scoreboard queue, plus reset/hold sequences.
// Rotate vectors are included when ALU_J_ROTATE_EN is defined.
module tb_alu_j;

  logic       clk;
  logic       rst_n;
  logic [4:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [7:0] param;
  logic [7:0] result;
  logic [2:0] status;
  logic [7:0] result_q;
  logic [2:0] status_q;

  alu_j dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .operand1 (operand1),
    .operand2 (operand2),
    .param    (param),
    .result   (result),
    .status   (status),
    .result_q (result_q),
    .status_q (status_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] res;
    logic [2:0] st;
    bit         upd;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [2:0] st;
  } exp_t;

  vec_t vecs[$];
  exp_t comb_q[$];
  exp_t reg_q[$];

  int tests  = 0;
  int failed = 0;

  logic [7:0] model_rq;
  logic [2:0] model_sq;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] p, input logic [7:0] res, input logic [2:0] st,
                         input bit upd);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.p = p; v.res = res; v.st = st; v.upd = upd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] p);
    opcode = op; operand1 = a; operand2 = b; param = p;
  endtask

  task automatic check_reg(input string tag);
    exp_t e;
    e = reg_q.pop_front();
    check({tag, " result_q"}, result_q, e.res);
    check({tag, " status_q"}, {5'd0, status_q}, {5'd0, e.st});
    $display("[TB] %s: result_q=%h status_q=%b", tag, result_q, status_q);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    drive(5'd0, 8'h00, 8'h00, 8'h00);

    //      op     A      B      P      res    st      upd
    add_vec(5'd1,  8'h01, 8'h03, 8'h00, 8'h04, 3'b000, 1);
    add_vec(5'd1,  8'hFF, 8'h02, 8'h00, 8'h01, 3'b001, 1);
    add_vec(5'd1,  8'hFF, 8'h01, 8'h00, 8'h00, 3'b001, 1);
    add_vec(5'd1,  8'h00, 8'h00, 8'h00, 8'h00, 3'b100, 1);
    add_vec(5'd3,  8'hCC, 8'hAA, 8'h00, 8'h88, 3'b000, 1);
    add_vec(5'd3,  8'hCC, 8'h33, 8'h00, 8'h00, 3'b100, 1);
    add_vec(5'd4,  8'hF0, 8'h0F, 8'h00, 8'hFF, 3'b000, 1);
    add_vec(5'd4,  8'h00, 8'h00, 8'h00, 8'h00, 3'b100, 1);
    add_vec(5'd5,  8'hF0, 8'h0F, 8'h00, 8'hF0, 3'b000, 1);
    add_vec(5'd5,  8'h00, 8'hAC, 8'h00, 8'h53, 3'b000, 1);
    add_vec(5'd5,  8'h12, 8'hFF, 8'h00, 8'h00, 3'b100, 1);
    add_vec(5'd6,  8'h0F, 8'hFF, 8'h00, 8'hF0, 3'b000, 1);
    add_vec(5'd6,  8'hAF, 8'h55, 8'h00, 8'hFA, 3'b000, 1);
    add_vec(5'd6,  8'hF0, 8'hF0, 8'h00, 8'h00, 3'b100, 1);
    add_vec(5'd2,  8'h3F, 8'h0F, 8'h00, 8'h30, 3'b000, 1);
    add_vec(5'd2,  8'h0E, 8'h0F, 8'h00, 8'hFF, 3'b010, 1);
    add_vec(5'd2,  8'h7E, 8'h7E, 8'h00, 8'h00, 3'b100, 1);
    add_vec(5'd7,  8'h81, 8'h00, 8'h01, 8'h02, 3'b001, 1);
    add_vec(5'd8,  8'h81, 8'h00, 8'h01, 8'h40, 3'b010, 1);
    add_vec(5'd9,  8'h00, 8'h00, 8'h5A, 8'h5A, 3'b000, 1);
    add_vec(5'd9,  8'hFF, 8'hFF, 8'h00, 8'h00, 3'b100, 1);
    add_vec(5'd7,  8'h81, 8'h00, 8'h09, 8'h02, 3'b001, 1);
    add_vec(5'd7,  8'h01, 8'h00, 8'h07, 8'h80, 3'b000, 1);
    add_vec(5'd8,  8'h01, 8'h00, 8'hF8, 8'h01, 3'b000, 1);
    add_vec(5'd8,  8'h80, 8'h00, 8'h07, 8'h01, 3'b000, 1);
    add_vec(5'd0,  8'hFF, 8'h01, 8'h00, 8'h00, 3'b000, 0);
    add_vec(5'd31, 8'hFF, 8'hFF, 8'h11, 8'h00, 3'b000, 0);
`ifdef ALU_J_ROTATE_EN
    add_vec(5'd10, 8'h81, 8'h00, 8'h01, 8'h03, 3'b000, 1);
    add_vec(5'd11, 8'h81, 8'h00, 8'h01, 8'hC0, 3'b000, 1);
    add_vec(5'd10, 8'h00, 8'h00, 8'h03, 8'h00, 3'b100, 1);
`else
    add_vec(5'd10, 8'h81, 8'h00, 8'h01, 8'h00, 3'b000, 0);
    add_vec(5'd11, 8'h81, 8'h00, 8'h01, 8'h00, 3'b000, 0);
`endif

    // Reset state with rst_n asserted.
    #1;
    check("reset result_q", result_q, 8'h00);
    check("reset status_q", {5'd0, status_q}, 8'h00);
    model_rq = 8'h00;
    model_sq = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p);
      e.res = vecs[i].res; e.st = vecs[i].st;
      comb_q.push_back(e);
      if (vecs[i].upd) begin
        model_rq = vecs[i].res;
        model_sq = vecs[i].st;
      end
      e.res = model_rq; e.st = model_sq;
      reg_q.push_back(e);
      #1;
      e = comb_q.pop_front();
      check($sformatf("vec%0d result", i), result, e.res);
      check($sformatf("vec%0d status", i), {5'd0, status}, {5'd0, e.st});
      $display("[TB] vec%0d op=%b A=%h B=%h P=%h -> result=%h status=%b",
               i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p, result, status);
      @(posedge clk);
      #1;
      check_reg($sformatf("vec%0d", i));
    end

    // Load a known value, then assert reset in the middle of the high phase.
    @(negedge clk);
    drive(5'd1, 8'h01, 8'h03, 8'h00);
    e.res = 8'h04; e.st = 3'b000; reg_q.push_back(e);
    @(posedge clk); #1;
    check_reg("load 1+3");
    #2;
    rst_n = 1'b0;
    #1;
    e.res = 8'h00; e.st = 3'b000; reg_q.push_back(e);
    check_reg("async reset mid-clock");
    @(posedge clk); #1;
    e.res = 8'h00; e.st = 3'b000; reg_q.push_back(e);
    check_reg("reset held over edge");

    // Release reset mid-cycle with ADD 255+1 pending; first edge captures it.
    @(negedge clk);
    drive(5'd1, 8'hFF, 8'h01, 8'h00);
    #2;
    rst_n = 1'b1;
    e.res = 8'h00; e.st = 3'b001; reg_q.push_back(e);
    @(posedge clk); #1;
    check_reg("ADD 255+1 after release");

    // NOP must leave the registers untouched.
    @(negedge clk);
    drive(5'd0, 8'h55, 8'h22, 8'h00);
    e.res = 8'h00; e.st = 3'b001; reg_q.push_back(e);
    @(posedge clk); #1;
    check_reg("NOP hold");

    @(negedge clk);
    drive(5'd9, 8'h00, 8'h00, 8'hA5);
    e.res = 8'hA5; e.st = 3'b000; reg_q.push_back(e);
    @(posedge clk); #1;
    check_reg("VAL A5 update");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
